// File: rtl/nios_debug_ocimem_sched_if.sv
// CPU debug-slave (Avalon) and OCI memory port bundle for the OCI memory scheduler.
interface nios_debug_ocimem_sched_if #(
    parameter int ADDR_W = 8
);
    logic              av_read;
    logic              av_write;
    logic [ADDR_W-1:0] av_address;
    logic [31:0]       av_writedata;
    logic              av_waitrequest;
    logic [31:0]       av_readdata;
    logic              av_readdatavalid;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  av_read, av_write, av_address, av_writedata, mem_rdata,
        output av_waitrequest, av_readdata, av_readdatavalid,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output av_read, av_write, av_address, av_writedata, mem_rdata,
        input  av_waitrequest, av_readdata, av_readdatavalid,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/nios_debug_ocimem_sched.sv
// Shares the OCI debug memory between a queued JTAG command stream and the CPU debug slave.
// Build option: NIOS_DEBUG_SCHED_JTAG_PRIORITY_EN makes a non-empty JTAG queue always win.
module nios_debug_ocimem_sched #(
    parameter int ADDR_W = 8,
    parameter int QDEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [37:0] jdo,
    input  logic        take_action_ocimem_a,
    input  logic        take_action_ocimem_b,
    input  logic        take_no_action_ocimem_a,
    nios_debug_ocimem_sched_if.slave bus,
    output logic [31:0] MonDReg,
    output logic        monitor_ready,
    output logic        jtag_overflow
);
    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {OP_ADDR, OP_WR, OP_RD} op_e;
    typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT} state_e;
    // Only jdo[34:3] is ever consumed; the load address sits inside it at jdo[ADDR_W+16:17].
    typedef struct packed {
        op_e         op;
        logic [31:0] pay;
    } jcmd_t;

    jcmd_t             q [QDEPTH];
    jcmd_t             enq_cmd, head;
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [CNT_W-1:0]  count;
    logic              q_full, q_empty, enq_any, enq_multi, enq, deq;
    state_e            state, state_nxt;
    logic              cur_av, cur_we, last_jtag, av_req, grant_j, grant_a;
    logic [ADDR_W-1:0] cur_addr, jaddr;
    logic [31:0]       cur_wdata;
    logic              unused_jdo;

    assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

    always_comb begin
        enq_cmd.pay = jdo[34:3];
        enq_cmd.op  = OP_RD;
        if (take_action_ocimem_a)      enq_cmd.op = OP_ADDR;
        else if (take_action_ocimem_b) enq_cmd.op = OP_WR;
    end

    assign enq_any   = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    assign enq_multi = (take_action_ocimem_a & take_action_ocimem_b) |
                       (take_action_ocimem_a & take_no_action_ocimem_a) |
                       (take_action_ocimem_b & take_no_action_ocimem_a);
    assign q_full    = (count == CNT_W'(QDEPTH));
    assign q_empty   = (count == '0);
    // A full queue still accepts when the head leaves in the same cycle.
    assign enq       = enq_any && (!q_full || deq);
    assign head      = q[rd_ptr];
    assign av_req    = bus.av_read | bus.av_write;

`ifdef NIOS_DEBUG_SCHED_JTAG_PRIORITY_EN
    assign grant_j = (state == IDLE) && !q_empty;
`else
    assign grant_j = (state == IDLE) && !q_empty && (!av_req || !last_jtag);
`endif
    assign grant_a = (state == IDLE) && av_req && !grant_j;
    assign deq     = grant_j;

    always_comb begin
        state_nxt            = state;
        bus.mem_en           = 1'b0;
        bus.mem_we           = 1'b0;
        bus.mem_addr         = cur_addr;
        bus.mem_wdata        = cur_wdata;
        bus.av_waitrequest   = 1'b1;
        bus.av_readdatavalid = 1'b0;
        bus.av_readdata      = '0;
        monitor_ready        = q_empty;
        case (state)
            IDLE: begin
                // Address loads complete inside IDLE without touching memory.
                if (grant_a || (grant_j && head.op != OP_ADDR)) state_nxt = ISSUE;
            end
            ISSUE: begin
                bus.mem_en         = 1'b1;
                bus.mem_we         = cur_we;
                bus.av_waitrequest = !cur_av;
                monitor_ready      = q_empty && cur_av;
                state_nxt          = cur_we ? IDLE : RDWAIT;
            end
            RDWAIT: begin
                bus.av_readdatavalid = cur_av;
                bus.av_readdata      = cur_av ? bus.mem_rdata : '0;
                monitor_ready        = q_empty && cur_av;
                state_nxt            = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (enq) q[wr_ptr] <= enq_cmd;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
            jaddr         <= '0;
            MonDReg       <= '0;
            jtag_overflow <= 1'b0;
            last_jtag     <= 1'b1;
            cur_av        <= 1'b0;
            cur_we        <= 1'b0;
            cur_addr      <= '0;
            cur_wdata     <= '0;
        end else begin
            state <= state_nxt;
            if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
            if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(enq) - CNT_W'(deq);
            if (enq_multi || (enq_any && !enq)) jtag_overflow <= 1'b1;
            if (grant_j) begin
                last_jtag <= 1'b1;
                if (head.op == OP_ADDR) begin
                    jaddr <= head.pay[ADDR_W+13:14];
                end else begin
                    cur_av    <= 1'b0;
                    cur_we    <= (head.op == OP_WR);
                    cur_addr  <= jaddr;
                    cur_wdata <= head.pay;
                    jaddr     <= jaddr + ADDR_W'(1);
                end
            end else if (grant_a) begin
                last_jtag <= 1'b0;
                cur_av    <= 1'b1;
                cur_we    <= bus.av_write;
                cur_addr  <= bus.av_address;
                cur_wdata <= bus.av_writedata;
            end
            if (state == RDWAIT && !cur_av) MonDReg <= bus.mem_rdata;
        end
    end
endmodule

// File: tb/tb_nios_debug_ocimem_sched.sv
// Randomised bench for nios_debug_ocimem_sched against a transaction-schedule reference model.
module tb_nios_debug_ocimem_sched;
    localparam int AW = 8;
    localparam int QD = 4;

    typedef struct {
        int          op;   // 0 addr load, 1 write, 2 read
        logic [37:0] d;
    } jent_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [37:0] jdo;
    logic        ta_a, ta_b, tn_a;
    logic [31:0] MonDReg;
    logic        monitor_ready, jtag_overflow;

    nios_debug_ocimem_sched_if #(.ADDR_W(AW)) bus ();

    nios_debug_ocimem_sched #(.ADDR_W(AW), .QDEPTH(QD)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (ta_a),
        .take_action_ocimem_b    (ta_b),
        .take_no_action_ocimem_a (tn_a),
        .bus                     (bus.slave),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .jtag_overflow           (jtag_overflow)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: pending JTAG commands, the timeline of the op in service, and sticky state.
    jent_t       mq[$];
    int          m_ph[$];   // remaining cycles of the current op: 1 = memory strobe, 2 = data return
    bit          m_av, m_we, m_lastj, m_ovf;
    logic [AW-1:0] m_addr, m_jaddr;
    logic [31:0] m_wdata, m_mond;
    int          m_acc_wr, jwr_obs;

    // Stimulus state
    logic [31:0] rdat;
    bit          fix_rd = 0, av_rd_only = 0, av_done = 0;
    int          av_pct = 0;
    logic [AW-1:0] obs_addr;
    bit          obs_we;
    logic [31:0] obs_wdata;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ph.delete();
        m_av = 0; m_we = 0; m_lastj = 1; m_ovf = 0;
        m_addr = '0; m_jaddr = '0; m_wdata = '0; m_mond = '0;
    endtask

    task automatic model_update();
        bit    jr, ar, tj;
        int    n;
        jent_t e;
        if (m_ph.size() != 0) begin
            if (m_ph[0] == 2 && !m_av) m_mond = rdat;
            void'(m_ph.pop_front());
        end else begin
            jr = (mq.size() != 0);
            ar = bus.av_read || bus.av_write;
`ifdef NIOS_DEBUG_SCHED_JTAG_PRIORITY_EN
            tj = jr;
`else
            tj = jr && (!ar || !m_lastj);
`endif
            if (tj) begin
                e = mq.pop_front();
                m_lastj = 1;
                if (e.op == 0) begin
                    m_jaddr = e.d[AW+16:17];
                end else begin
                    m_av = 0; m_we = (e.op == 1); m_addr = m_jaddr; m_wdata = e.d[34:3];
                    m_jaddr = m_jaddr + 1'b1;
                    m_ph.push_back(1);
                    if (!m_we) m_ph.push_back(2);
                end
            end else if (ar) begin
                m_lastj = 0;
                m_av = 1; m_we = bus.av_write; m_addr = bus.av_address; m_wdata = bus.av_writedata;
                m_ph.push_back(1);
                if (!m_we) m_ph.push_back(2);
            end
        end
        n = int'(ta_a) + int'(ta_b) + int'(tn_a);
        if (n > 1) m_ovf = 1;
        if (n > 0) begin
            e.d  = jdo;
            e.op = ta_a ? 0 : (ta_b ? 1 : 2);
            if (mq.size() < QD) begin
                mq.push_back(e);
                if (e.op == 1) m_acc_wr++;
            end else begin
                m_ovf = 1;
            end
        end
    endtask

    // One clock: compare mid-cycle, advance the model, then drive next cycle's inputs.
    task automatic cycle();
        int ph;
        bit rv;
        @(negedge clk);
        ph = (m_ph.size() != 0) ? m_ph[0] : 0;
        rv = (ph == 2) && m_av;
        chk("mem_en", 64'(bus.mem_en), 64'(ph == 1));
        if (ph == 1) begin
            chk("mem_we", 64'(bus.mem_we), 64'(m_we));
            chk("mem_addr", 64'(bus.mem_addr), 64'(m_addr));
            if (m_we) chk("mem_wdata", 64'(bus.mem_wdata), 64'(m_wdata));
        end
        chk("av_waitrequest", 64'(bus.av_waitrequest), 64'(!(ph == 1 && m_av)));
        chk("av_readdatavalid", 64'(bus.av_readdatavalid), 64'(rv));
        chk("av_readdata", 64'(bus.av_readdata), 64'(rv ? rdat : 32'h0));
        chk("MonDReg", 64'(MonDReg), 64'(m_mond));
        chk("monitor_ready", 64'(monitor_ready),
            64'((mq.size() == 0) && !(m_ph.size() != 0 && !m_av)));
        chk("jtag_overflow", 64'(jtag_overflow), 64'(m_ovf));
        if (bus.mem_en) begin
            obs_addr = bus.mem_addr; obs_we = bus.mem_we; obs_wdata = bus.mem_wdata;
            if (bus.mem_we && bus.av_waitrequest) jwr_obs++;
        end
        av_done = (bus.av_read || bus.av_write) && !bus.av_waitrequest;
        if (!reset_n) model_reset();
        else          model_update();
        @(posedge clk);
        #1;
        ta_a = 0; ta_b = 0; tn_a = 0;
        rdat = fix_rd ? 32'h12345678 : $urandom;
        bus.mem_rdata = rdat;
        if (av_done) begin
            bus.av_read = 0; bus.av_write = 0;
        end
        if (!bus.av_read && !bus.av_write && reset_n && ($urandom_range(99) < av_pct)) begin
            if (av_rd_only || $urandom_range(1) == 1) bus.av_read = 1;
            else bus.av_write = 1;
            bus.av_address   = AW'($urandom);
            bus.av_writedata = $urandom;
        end
    endtask

    task automatic strobe(input bit a, input bit b, input bit r, input logic [37:0] d);
        ta_a = a; ta_b = b; tn_a = r; jdo = d;
        cycle();
    endtask

    function automatic logic [37:0] jdo_addr(input logic [AW-1:0] a);
        logic [37:0] v;
        v = {6'($urandom), $urandom};
        v[AW+16:17] = a;
        return v;
    endfunction

    function automatic logic [37:0] jdo_data(input logic [31:0] w);
        logic [37:0] v;
        v = {6'($urandom), $urandom};
        v[34:3] = w;
        return v;
    endfunction

    task automatic drain();
        av_pct = 0;
        for (int i = 0; i < 200; i++) begin
            if (mq.size() == 0 && m_ph.size() == 0 && !bus.av_read && !bus.av_write) return;
            cycle();
        end
        chk("drain_timeout", 64'(1), 64'(0));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1);
    end

    initial begin
        bit found;
        reset_n = 0; jdo = '0; ta_a = 0; ta_b = 0; tn_a = 0;
        bus.av_read = 0; bus.av_write = 0; bus.av_address = '0; bus.av_writedata = '0;
        rdat = '0; bus.mem_rdata = '0;
        obs_addr = '0; obs_we = 0; obs_wdata = '0; m_acc_wr = 0; jwr_obs = 0;
        model_reset();
        repeat (3) cycle();
        reset_n = 1;

        // Address load then write; the following read must land on the post-incremented address.
        strobe(1, 0, 0, jdo_addr(8'h10));
        strobe(0, 1, 0, jdo_data(32'hDEADBEEF));
        repeat (4) cycle();
        chk("wr_addr", 64'(obs_addr), 64'h10);
        chk("wr_data", 64'(obs_wdata), 64'hDEADBEEF);
        chk("wr_we", 64'(obs_we), 64'h1);
        strobe(0, 0, 1, jdo_data($urandom));
        repeat (4) cycle();
        chk("addr_inc", 64'(obs_addr), 64'h11);

        // Read at the top address wraps the JTAG address to zero.
        fix_rd = 1;
        strobe(1, 0, 0, jdo_addr(8'hFF));
        strobe(0, 0, 1, jdo_data($urandom));
        repeat (5) cycle();
        chk("rd_top_addr", 64'(obs_addr), 64'hFF);
        chk("mondreg_rd", 64'(MonDReg), 64'h12345678);
        chk("monitor_ready_ret", 64'(monitor_ready), 64'h1);
        fix_rd = 0;
        strobe(0, 0, 1, jdo_data($urandom));
        repeat (5) cycle();
        chk("addr_wrap", 64'(obs_addr), 64'h00);

        // Write burst while the CPU keeps issuing reads.
        av_pct = 100; av_rd_only = 1;
        repeat (3) cycle();
        m_acc_wr = 0; jwr_obs = 0;
        for (int i = 0; i < 5; i++) strobe(0, 1, 0, jdo_data($urandom));
        repeat (30) cycle();
        drain();
        chk("burst_writes", 64'(jwr_obs), 64'(m_acc_wr));

        // Continuous CPU reads competing with queued JTAG reads.
        av_pct = 100; av_rd_only = 1;
        repeat (2) cycle();
        for (int i = 0; i < 3; i++) strobe(0, 0, 1, jdo_data($urandom));
        repeat (30) cycle();
        drain();

        // Random traffic, including simultaneous strobes and queue saturation.
        av_rd_only = 0;
        for (int i = 0; i < 2000; i++) begin
            av_pct = (i % 400 < 200) ? 60 : 20;
            if ($urandom_range(99) < 35) begin
                ta_a = ($urandom_range(9) == 0);
                ta_b = ($urandom_range(2) == 0);
                tn_a = ($urandom_range(2) == 0);
                jdo  = {6'($urandom), $urandom};
            end
            cycle();
        end
        drain();

        // Reset asserted while a CPU read is waiting for its data.
        av_pct = 100; av_rd_only = 1;
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            cycle();
            if (m_ph.size() != 0 && m_ph[0] == 2 && m_av) found = 1;
        end
        chk("rdwait_reached", 64'(found), 64'(1));
        av_pct = 0;
        reset_n = 0;
        bus.av_read = 0; bus.av_write = 0;
        #1;
        chk("rst_rdvalid", 64'(bus.av_readdatavalid), 64'(0));
        chk("rst_waitreq", 64'(bus.av_waitrequest), 64'(1));
        chk("rst_mondreg", 64'(MonDReg), 64'(0));
        chk("rst_ovf", 64'(jtag_overflow), 64'(0));
        chk("rst_ready", 64'(monitor_ready), 64'(1));
        model_reset();
        repeat (2) cycle();
        reset_n = 1;
        repeat (6) cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
